// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan driver: shifts COLS pixels per row pair from a 1-cycle-latency framebuffer, latches, then lights BASE_ON<<plane clocks.
// No backpressure; outputs decode straight from flops, and enable is only honoured at IDLE and at plane boundaries (BLANK).
module hub75_bcm_scanner #(
  parameter int COLS      = 64,
  parameter int ADDR_BITS = 4,
  parameter int PLANES    = 4,
  parameter int BASE_ON   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  output logic                              fb_rd,
  output logic [ADDR_BITS+$clog2(COLS)-1:0] fb_addr,
  input  logic [3*PLANES-1:0]               fb_data0,
  input  logic [3*PLANES-1:0]               fb_data1,
  output logic [ADDR_BITS-1:0]              row_addr,
  output logic                              r0,
  output logic                              g0,
  output logic                              b0,
  output logic                              r1,
  output logic                              g1,
  output logic                              b1,
  output logic                              sclk,
  output logic                              lat,
  output logic                              oe_n,
  output logic                              frame_start
);

  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(2*COLS+1);
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int DW = $clog2(BASE_ON << (PLANES-1)) + 1;
  localparam logic [SW-1:0] SHIFT_LAST = SW'(2*COLS);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES-1);

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DISPLAY, BLANK} state_t;

  state_t               state, state_nx;
  logic [SW-1:0]        cnt;
  logic [DW-1:0]        dcnt;
  logic [DW-1:0]        on_len;
  logic [PW-1:0]        plane;
  logic [ADDR_BITS-1:0] row;
  logic [5:0]           held;
  logic [5:0]           live;
  logic [5:0]           colour;
  logic                 shift_done;
  logic                 disp_done;

  assign on_len     = DW'(BASE_ON) << plane;
  assign shift_done = (cnt == SHIFT_LAST);
  assign disp_done  = (dcnt == on_len - DW'(1));

  // Current-plane bit of each channel, ordered {r0,g0,b0,r1,g1,b1}.
  always_comb begin
    live = 6'd0;
    for (int p = 0; p < PLANES; p++) begin
      if (plane == PW'(p))
        live = {fb_data0[2*PLANES+p], fb_data0[PLANES+p], fb_data0[p],
                fb_data1[2*PLANES+p], fb_data1[PLANES+p], fb_data1[p]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // cnt: 0 = prefetch, odd = phase 0 (data returns), even = phase 1 (sclk high, next read issued).
  always_comb begin
    state_nx    = state;
    fb_rd       = 1'b0;
    sclk        = 1'b0;
    lat         = 1'b0;
    oe_n        = 1'b1;
    frame_start = 1'b0;
    colour      = 6'd0;
    case (state)
      IDLE: begin
        if (enable) state_nx = SHIFT;
      end
      SHIFT: begin
        fb_rd       = !cnt[0] && !shift_done;
        frame_start = (cnt == '0) && (row == '0) && (plane == '0);
        if (cnt != '0) begin
          sclk   = !cnt[0];
          colour = cnt[0] ? live : held;
        end
        if (shift_done) state_nx = LATCH;
      end
      LATCH: begin
        lat      = 1'b1;
        state_nx = DISPLAY;
      end
      DISPLAY: begin
        oe_n = 1'b0;
        if (disp_done) state_nx = BLANK;
      end
      BLANK: begin
        state_nx = enable ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign {r0, g0, b0, r1, g1, b1} = colour;
  assign fb_addr = fb_rd ? {row, cnt[CW:1]} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dcnt     <= '0;
      plane    <= '0;
      row      <= '0;
      row_addr <= '0;
      held     <= '0;
    end else begin
      if (state == SHIFT) begin
        cnt <= shift_done ? '0 : cnt + SW'(1);
        if (cnt[0])     held     <= live;
        // Loading on SHIFT exit makes the new address visible during LATCH, while oe_n is still high.
        if (shift_done) row_addr <= row;
      end
      dcnt <= (state == DISPLAY) ? dcnt + DW'(1) : '0;
      if (state == BLANK) begin
        if (plane == PLANE_LAST) begin
          plane <= '0;
          row   <= row + ADDR_BITS'(1);
        end else begin
          plane <= plane + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner with COLS=4, ADDR_BITS=1, PLANES=2, BASE_ON=2 (plane 13/15 clocks, row 28, frame 56).
module tb_hub75_bcm_scanner;
  localparam int COLS      = 4;
  localparam int ADDR_BITS = 1;
  localparam int PLANES    = 2;
  localparam int BASE_ON   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       fb_rd;
  logic [2:0] fb_addr;
  logic [5:0] fb_data0;
  logic [5:0] fb_data1;
  logic [0:0] row_addr;
  logic       r0, g0, b0, r1, g1, b1;
  logic       sclk, lat, oe_n, frame_start;

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0]  top_mem [8];
  logic [5:0]  bot_mem [8];
  logic [79:0] v_sclk, v_lat, v_oen, v_rd, v_fs;
  logic [5:0]  v_col  [80];
  logic        v_row  [80];
  logic [2:0]  v_addr [80];

  hub75_bcm_scanner #(
    .COLS(COLS), .ADDR_BITS(ADDR_BITS), .PLANES(PLANES), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data0(fb_data0), .fb_data1(fb_data1),
    .row_addr(row_addr),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .sclk(sclk), .lat(lat), .oe_n(oe_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // One-cycle-latency RAM; junk on cycles without a read so mistimed sampling shows up.
  always @(posedge clk) begin
    fb_data0 <= fb_rd ? top_mem[fb_addr] : 6'($urandom);
    fb_data1 <= fb_rd ? bot_mem[fb_addr] : 6'($urandom);
  end

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic fill(input logic [5:0] t, input logic [5:0] b);
    for (int i = 0; i < 8; i++) begin
      top_mem[i] = t;
      bot_mem[i] = b;
    end
  endtask

  task automatic capture(input int n, input int drop_at);
    v_sclk = '0; v_lat = '0; v_oen = '0; v_rd = '0; v_fs = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v_sclk[i] = sclk;
      v_lat[i]  = lat;
      v_oen[i]  = oe_n;
      v_rd[i]   = fb_rd;
      v_fs[i]   = frame_start;
      v_col[i]  = {r0, g0, b0, r1, g1, b1};
      v_row[i]  = row_addr[0];
      v_addr[i] = fb_addr;
      if (i == drop_at) enable = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst    = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({fb_rd, fb_addr, frame_start} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_fb: got %b want 00000", {fb_rd, fb_addr, frame_start});
    end
    vectors++;
    if ({sclk, lat, oe_n} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_ctrl {sclk,lat,oe_n}: got %b want 001", {sclk, lat, oe_n});
    end
    vectors++;
    if ({r0, g0, b0, r1, g1, b1} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_colour: got %b want 000000", {r0, g0, b0, r1, g1, b1});
    end
    vectors++;
    if (row_addr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_row_addr: got %b want 0", row_addr);
    end
    enable = 1'b0;
    rst    = 1'b1;
    bad    = 0;
    repeat (20) begin
      @(negedge clk);
      if (oe_n !== 1'b1 || fb_rd !== 1'b0 || sclk !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_shift_ones();
    int good;
    do_reset();
    fill(6'h3F, 6'h3F);
    enable = 1'b1;
    capture(28, -1);
    vectors++;
    if (v_sclk[27:0] !== 28'h02A8154) begin
      miscompares++;
      $display("FAIL sclk_pattern: got %h want 02a8154", v_sclk[27:0]);
    end
    vectors++;
    if (v_lat[27:0] !== 28'h0400200) begin
      miscompares++;
      $display("FAIL lat_pattern: got %h want 0400200", v_lat[27:0]);
    end
    vectors++;
    if (v_rd[27:0] !== 28'h00AA055) begin
      miscompares++;
      $display("FAIL fb_rd_pattern: got %h want 00aa055", v_rd[27:0]);
    end
    vectors++;
    if (v_fs[27:0] !== 28'h0000001) begin
      miscompares++;
      $display("FAIL frame_start_row0: got %h want 0000001", v_fs[27:0]);
    end
    good = 0;
    for (int i = 0; i < 28; i++)
      if (v_sclk[i] && v_col[i] === 6'h3F) good++;
    vectors++;
    if (good != 8) begin
      miscompares++;
      $display("FAIL colour_at_sclk: got %0d ones-at-rise want 8", good);
    end
    vectors++;
    if ({v_col[10], v_col[11]} !== 12'h000) begin
      miscompares++;
      $display("FAIL colour_in_display: got %h want 000", {v_col[10], v_col[11]});
    end
    vectors++;
    if (v_addr[6] !== 3'b011) begin
      miscompares++;
      $display("FAIL fb_addr_col3: got %b want 011", v_addr[6]);
    end
  endtask

  task automatic test_bcm_timing();
    logic [79:0] exp_fs;
    do_reset();
    fill(6'h00, 6'h00);
    enable = 1'b1;
    capture(70, -1);
    vectors++;
    if (v_oen[55:0] !== {28'h87FF3FF, 28'h87FF3FF}) begin
      miscompares++;
      $display("FAIL oe_runs: got %h want %h", v_oen[55:0], {28'h87FF3FF, 28'h87FF3FF});
    end
    exp_fs     = '0;
    exp_fs[0]  = 1'b1;
    exp_fs[56] = 1'b1;
    vectors++;
    if (v_fs[69:0] !== exp_fs[69:0]) begin
      miscompares++;
      $display("FAIL frame_period: got %h want %h", v_fs[69:0], exp_fs[69:0]);
    end
  endtask

  task automatic test_pixel();
    do_reset();
    fill(6'h00, 6'h00);
    top_mem[0] = 6'b100000;
    bot_mem[0] = 6'b000001;
    enable = 1'b1;
    capture(28, -1);
    vectors++;
    if (v_col[1] !== 6'b000001) begin
      miscompares++;
      $display("FAIL pix_p0_phase0: got %b want 000001", v_col[1]);
    end
    vectors++;
    if (v_col[2] !== 6'b000001) begin
      miscompares++;
      $display("FAIL pix_p0_phase1: got %b want 000001", v_col[2]);
    end
    vectors++;
    if (v_col[4] !== 6'b000000) begin
      miscompares++;
      $display("FAIL pix_p0_col1: got %b want 000000", v_col[4]);
    end
    vectors++;
    if (v_col[14] !== 6'b100000) begin
      miscompares++;
      $display("FAIL pix_p1_phase0: got %b want 100000", v_col[14]);
    end
    vectors++;
    if (v_col[15] !== 6'b100000) begin
      miscompares++;
      $display("FAIL pix_p1_phase1: got %b want 100000", v_col[15]);
    end
  endtask

  task automatic test_row_seq();
    int changes;
    int bad;
    do_reset();
    fill(6'h15, 6'h2A);
    enable = 1'b1;
    capture(70, -1);
    vectors++;
    if ({v_row[36], v_row[37], v_row[64], v_row[65]} !== 4'b0110) begin
      miscompares++;
      $display("FAIL row_addr_seq: got %b want 0110",
               {v_row[36], v_row[37], v_row[64], v_row[65]});
    end
    changes = 0;
    bad     = 0;
    for (int i = 1; i < 70; i++) begin
      if (v_row[i] !== v_row[i-1]) begin
        changes++;
        if (!(v_lat[i] && v_oen[i])) bad++;
      end
    end
    vectors++;
    if (changes != 2 || bad != 0) begin
      miscompares++;
      $display("FAIL row_change_window: got %0d changes %0d outside latch want 2 and 0", changes, bad);
    end
    vectors++;
    if ({v_rd[28], v_addr[28], v_addr[34], v_addr[56]} !== 10'b1_100_111_000) begin
      miscompares++;
      $display("FAIL fb_addr_row: got %b want 1100111000",
               {v_rd[28], v_addr[28], v_addr[34], v_addr[56]});
    end
  endtask

  task automatic test_reset_mid_display();
    logic found;
    do_reset();
    fill(6'h3F, 6'h00);
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (oe_n === 1'b0) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reach_display: got no oe_n low within 40 clocks want oe_n low");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (oe_n !== 1'b1) begin
      miscompares++;
      $display("FAIL async_oe_off: got %b want 1", oe_n);
    end
    vectors++;
    if ({sclk, lat, fb_rd, row_addr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_ctrl: got %b want 0000", {sclk, lat, fb_rd, row_addr});
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    fill(6'h3F, 6'h3F);
    enable = 1'b1;
    capture(30, 3);
    vectors++;
    if (v_oen[29:0] !== 30'h3FFFF3FF) begin
      miscompares++;
      $display("FAIL drop_oe: got %h want 3ffff3ff", v_oen[29:0]);
    end
    vectors++;
    if (v_rd[29:0] !== 30'h00000055 || v_sclk[29:0] !== 30'h00000154) begin
      miscompares++;
      $display("FAIL drop_idle: got rd %h sclk %h want 00000055 00000154", v_rd[29:0], v_sclk[29:0]);
    end
    enable = 1'b1;
    capture(16, -1);
    vectors++;
    if (v_fs[15:0] !== 16'h0000) begin
      miscompares++;
      $display("FAIL resume_no_frame_start: got %h want 0000", v_fs[15:0]);
    end
    vectors++;
    if (v_oen[15:0] !== 16'hC3FF) begin
      miscompares++;
      $display("FAIL resume_plane1_on: got %h want c3ff", v_oen[15:0]);
    end
    vectors++;
    if ({v_row[9], v_rd[15], v_addr[15], v_col[2]} !== {1'b0, 1'b1, 3'b100, 6'h3F}) begin
      miscompares++;
      $display("FAIL resume_counters: got %b want 011003f-equivalent %b",
               {v_row[9], v_rd[15], v_addr[15], v_col[2]}, {1'b0, 1'b1, 3'b100, 6'h3F});
    end
  endtask

  initial begin
    fill(6'h00, 6'h00);
    test_reset();
    test_shift_ones();
    test_bcm_timing();
    test_pixel();
    test_row_seq();
    test_reset_mid_display();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
